// File: rtl/tdm_demux_4to1.sv
// tdm_demux_4to1 -- receive side of a 4-slot TDM link.
// A frame is four strobed slots (x0..x3) with sync marking slot 0. Slots 0..2
// are held in shadow registers. The whole frame is copied to y0..y3 on the
// slot-3 strobe, so a frame always appears on the outputs all at once.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   en            slot strobe; sync/din are ignored when en=0
//   sync          frame marker on slot 0
//   din [W-1:0]   sample for the current slot
//   err_clr       clears the sticky sync_err flag
//   y0..y3        last complete frame
//   sel [1:0]     slot index expected on the next strobe
//   locked        1 while frame alignment is held
//   frame_valid   one-cycle pulse when y0..y3 update
//   sync_err      sticky alignment error
module tdm_demux_4to1 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sync,
  input  logic [W-1:0] din,
  input  logic         err_clr,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [1:0]   sel,
  output logic         locked,
  output logic         frame_valid,
  output logic         sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [W-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic         fv_q, fv_d;
  logic         err_q, err_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    fv_d    = 1'b0;
    // Clear first so that an error detected on the same edge sets the flag again.
    err_d   = err_clr ? 1'b0 : err_q;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            s0_d    = din;
            sel_d   = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // A sync on any slot other than 0 drops the partial frame.
            // Alignment restarts from this sample.
            if (sel_q != 2'd0) err_d = 1'b1;
            s0_d  = din;
            sel_d = 2'd1;
          end else begin
            unique case (sel_q)
              2'd0: begin
                // Slot 0 arrived without sync, so alignment is lost.
                err_d   = 1'b1;
                state_d = HUNT;
              end
              2'd1: begin
                s1_d  = din;
                sel_d = 2'd2;
              end
              2'd2: begin
                s2_d  = din;
                sel_d = 2'd3;
              end
              default: begin
                y0_d  = s0_q;
                y1_d  = s1_q;
                y2_d  = s2_q;
                y3_d  = din;
                fv_d  = 1'b1;
                sel_d = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sel_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign sel         = sel_q;
  assign locked      = (state_q == LOCKED);
  assign frame_valid = fv_q;
  assign sync_err    = err_q;

endmodule
